vc_pop_scheduler: RTL and testbench
===================================

// Module: vc_pop_scheduler
// PURPOSE
//  Sequencer between the main FIFO and the two virtual-channel FIFOs (VC0/VC1).
//  Loads the almost-full/almost-empty thresholds into all FIFOs after reset.
//  Pops the main FIFO only when neither VC is paused and routes each word to a VC by its class bit.
//  Counts routed words per VC, detects FIFO errors and reports global idle.
// PARAMETERS
//  DATA_SIZE  6            data word width
//  CLASS_BIT  DATA_SIZE-1  bit of the word that selects the VC (0 -> VC0, 1 -> VC1)
//  THR_W      2            threshold width
//  CNT_W      8            per-VC routed-word counter width
// PORTS
//  clk             in   1          single clock, all logic on posedge
//  reset_L         in   1          synchronous, active-low reset
//  init            in   1          1 = (re)load thresholds
//  umbral_MF_af    in   THR_W      main almost-full threshold input
//  umbral_MF_ae    in   THR_W      main almost-empty threshold input
//  umbral_VC_af    in   THR_W      VC almost-full threshold input
//  umbral_VC_ae    in   THR_W      VC almost-empty threshold input
//  fifo_empty_main in   1          main FIFO empty
//  fifo_error_main in   1          main FIFO error
//  data_demux_vc   in   DATA_SIZE  main FIFO registered read data
//  pause_vc0/1     in   1          VC almost-full (backpressure)
//  error_vc0/1     in   1          VC FIFO error
//  empty_vc0/1     in   1          VC FIFO empty
//  pop_main        out  1          pop request to main FIFO (combinational)
//  push_vc0/1      out  1          push to VC FIFO (registered)
//  data_vc         out  DATA_SIZE  data to VC FIFOs (registered)
//  afMF_o/aeMF_o   out  THR_W      latched main thresholds
//  afVC_o/aeVC_o   out  THR_W      latched VC thresholds
//  state           out  3          FSM state
//  cnt_vc0/1       out  CNT_W      words pushed per VC, wrap at 2**CNT_W
//  error_out       out  1          sticky error
//  idle_out        out  1          whole path drained (combinational)
// BEHAVIOUR
//  Reset (reset_L=0 at posedge):
//   - state=RESET; all registered outputs, thresholds, counters and pend to 0.
//   - Reset overrides everything, including in-flight words, which are dropped.
//  FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
//   - RESET  -> INIT unconditionally on the first cycle with reset_L=1.
//   - INIT   -> thresholds latched from umbral_* on every cycle while in INIT; -> IDLE when init=0.
//   - IDLE   -> ACTIVE on the edge where pop_main=1.
//   - ACTIVE -> IDLE when fifo_empty_main=1 and pend=0.
//   - IDLE/ACTIVE -> INIT when init=1; ERROR takes priority over INIT.
//   - Any state except RESET -> ERROR when fifo_error_main|error_vc0|error_vc1 is sampled 1.
//   - ERROR is sticky until reset.
//  Pop and route:
//   - pop_main = (state IDLE|ACTIVE) & !init & !fifo_empty_main & !pause_vc0 & !pause_vc1 & !error inputs.
//   - pend <= pop_main. Read data is valid in cycle N+1 after a pop in cycle N.
//   - In cycle N+1, if pend=1 and the FSM is not entering ERROR: register data_vc <= data_demux_vc.
//     Also register push_vc1 <= data_demux_vc[CLASS_BIT] and push_vc0 <= its inverse.
//     Result: push seen in cycle N+2, 2-cycle pop-to-push latency. Back-to-back pops give one push per cycle.
//   - A pend already in flight still completes its push when the FSM enters INIT.
//   - push_vc0/push_vc1 are never both 1. Both are 0 when pend=0 and in ERROR.
//   - data_vc holds its last value when no push.
//   - cnt_vcX increments on each registered push_vcX and wraps from 2**CNT_W-1 to 0.
//   - Pause is sampled only at pop time; up to 2 words may still arrive after pause rises.
//     System rule: the VC af threshold leaves >=2 free entries.
//  Status:
//   - error_out registered: 1 from the edge entering ERROR.
//   - idle_out = (state==IDLE) & fifo_empty_main & empty_vc0 & empty_vc1 & !pend & !push_vc0 & !push_vc1.
// TESTING
//  1 reset_L=0 for 3 clk -> all outputs 0, state=0; release -> state=1 next edge.
//  2 INIT, init=1, umbral 3/1/2/1 -> afMF_o=3, aeMF_o=1, afVC_o=2, aeVC_o=1; init=0 -> state=2.
//  3 main holds 6'h25 then 6'h05 -> pop_main cycles N,N+1; push_vc1 data_vc=6'h25 at N+2;
//    push_vc0 data_vc=6'h05 at N+3; cnt_vc1=1, cnt_vc0=1; state returns to IDLE, then idle_out=1.
//  4 pause_vc0=1, main non-empty -> pop_main=0 held; pause_vc0=0 -> pop_main=1 same cycle.
//  5 error_vc1 one-cycle pulse mid-stream -> state=4, error_out=1, pop/push 0 until reset_L=0.
//  6 256 words of class 0 -> cnt_vc0 wraps to 0, cnt_vc1 stays 0.

Source files
------------

// File: rtl/vc_pop_scheduler.sv
// vc_pop_scheduler: sequencer between the main FIFO and the two VC FIFOs.
// It loads the FIFO thresholds after reset and pops the main FIFO while no VC is paused.
// Each popped word is routed to VC0 or VC1 by its class bit, with two cycles of latency.
// It also counts the words routed to each VC, latches errors and reports global idle.
module vc_pop_scheduler #(
    parameter int unsigned DATA_SIZE = 6,
    parameter int unsigned CLASS_BIT = DATA_SIZE - 1,
    parameter int unsigned THR_W     = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [THR_W-1:0]     umbral_MF_af,
    input  logic [THR_W-1:0]     umbral_MF_ae,
    input  logic [THR_W-1:0]     umbral_VC_af,
    input  logic [THR_W-1:0]     umbral_VC_ae,
    input  logic                 fifo_empty_main,
    input  logic                 fifo_error_main,
    input  logic [DATA_SIZE-1:0] data_demux_vc,
    input  logic                 pause_vc0,
    input  logic                 pause_vc1,
    input  logic                 error_vc0,
    input  logic                 error_vc1,
    input  logic                 empty_vc0,
    input  logic                 empty_vc1,
    output logic                 pop_main,
    output logic                 push_vc0,
    output logic                 push_vc1,
    output logic [DATA_SIZE-1:0] data_vc,
    output logic [THR_W-1:0]     afMF_o,
    output logic [THR_W-1:0]     aeMF_o,
    output logic [THR_W-1:0]     afVC_o,
    output logic [THR_W-1:0]     aeVC_o,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     cnt_vc0,
    output logic [CNT_W-1:0]     cnt_vc1,
    output logic                 error_out,
    output logic                 idle_out
);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StError  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   pend_q;
    logic                   push_vc0_q, push_vc1_q;
    logic [DATA_SIZE-1:0]   data_vc_q;
    logic [THR_W-1:0]       af_mf_q, ae_mf_q, af_vc_q, ae_vc_q;
    logic [CNT_W-1:0]       cnt_vc0_q, cnt_vc1_q;
    logic                   error_q;

    logic err_in;
    logic enter_err;
    logic do_push;

    // Pop gating, error detection and next-state selection.
    always_comb begin
        err_in    = fifo_error_main | error_vc0 | error_vc1;
        enter_err = (state_q != StReset) & err_in;
        pop_main  = ((state_q == StIdle) | (state_q == StActive)) & ~init & ~fifo_empty_main &
                    ~pause_vc0 & ~pause_vc1 & ~err_in;
        // A word popped last cycle is forwarded unless an error cuts it off.
        do_push   = pend_q & ~enter_err & (state_q != StError);

        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StInit;
            StInit: begin
                if (enter_err)  state_d = StError;
                else if (!init) state_d = StIdle;
            end
            StIdle: begin
                if (enter_err)     state_d = StError;
                else if (init)     state_d = StInit;
                else if (pop_main) state_d = StActive;
            end
            StActive: begin
                if (enter_err)                      state_d = StError;
                else if (init)                      state_d = StInit;
                else if (fifo_empty_main && !pend_q) state_d = StIdle;
            end
            StError:  state_d = StError;
            default:  state_d = StReset;
        endcase
    end

    // All sequential state: FSM, routing pipeline, thresholds, counters and sticky error.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q    <= StReset;
            pend_q     <= 1'b0;
            push_vc0_q <= 1'b0;
            push_vc1_q <= 1'b0;
            data_vc_q  <= '0;
            af_mf_q    <= '0;
            ae_mf_q    <= '0;
            af_vc_q    <= '0;
            ae_vc_q    <= '0;
            cnt_vc0_q  <= '0;
            cnt_vc1_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pop_main;
            if (do_push) begin
                data_vc_q  <= data_demux_vc;
                push_vc1_q <= data_demux_vc[CLASS_BIT];
                push_vc0_q <= ~data_demux_vc[CLASS_BIT];
            end else begin
                push_vc0_q <= 1'b0;
                push_vc1_q <= 1'b0;
            end
            if (state_q == StInit) begin
                af_mf_q <= umbral_MF_af;
                ae_mf_q <= umbral_MF_ae;
                af_vc_q <= umbral_VC_af;
                ae_vc_q <= umbral_VC_ae;
            end
            // Counters follow the registered push strobes and wrap naturally.
            cnt_vc0_q <= cnt_vc0_q + {{(CNT_W-1){1'b0}}, push_vc0_q};
            cnt_vc1_q <= cnt_vc1_q + {{(CNT_W-1){1'b0}}, push_vc1_q};
            if (enter_err) error_q <= 1'b1;
        end
    end

    // Output mapping and combinational idle detect.
    always_comb begin
        push_vc0  = push_vc0_q;
        push_vc1  = push_vc1_q;
        data_vc   = data_vc_q;
        afMF_o    = af_mf_q;
        aeMF_o    = ae_mf_q;
        afVC_o    = af_vc_q;
        aeVC_o    = ae_vc_q;
        state     = state_q;
        cnt_vc0   = cnt_vc0_q;
        cnt_vc1   = cnt_vc1_q;
        error_out = error_q;
        idle_out  = (state_q == StIdle) & fifo_empty_main & empty_vc0 & empty_vc1 & ~pend_q &
                    ~push_vc0_q & ~push_vc1_q;
    end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Self-checking bench for vc_pop_scheduler.
// Directed scenarios and randomized traffic are checked against a cycle-level reference model.
module tb_vc_pop_scheduler;

    localparam int DW = 6;
    localparam int CB = DW - 1;
    localparam int TW = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_L, init;
    logic [TW-1:0] umbral_MF_af, umbral_MF_ae, umbral_VC_af, umbral_VC_ae;
    logic          fifo_empty_main, fifo_error_main;
    logic [DW-1:0] data_demux_vc;
    logic          pause_vc0, pause_vc1, error_vc0, error_vc1, empty_vc0, empty_vc1;
    logic          pop_main, push_vc0, push_vc1;
    logic [DW-1:0] data_vc;
    logic [TW-1:0] afMF_o, aeMF_o, afVC_o, aeVC_o;
    logic [2:0]    state;
    logic [CW-1:0] cnt_vc0, cnt_vc1;
    logic          error_out, idle_out;

    vc_pop_scheduler #(.DATA_SIZE(DW), .CLASS_BIT(CB), .THR_W(TW), .CNT_W(CW)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_MF_af(umbral_MF_af), .umbral_MF_ae(umbral_MF_ae),
        .umbral_VC_af(umbral_VC_af), .umbral_VC_ae(umbral_VC_ae),
        .fifo_empty_main(fifo_empty_main), .fifo_error_main(fifo_error_main),
        .data_demux_vc(data_demux_vc),
        .pause_vc0(pause_vc0), .pause_vc1(pause_vc1),
        .error_vc0(error_vc0), .error_vc1(error_vc1),
        .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
        .pop_main(pop_main), .push_vc0(push_vc0), .push_vc1(push_vc1), .data_vc(data_vc),
        .afMF_o(afMF_o), .aeMF_o(aeMF_o), .afVC_o(afVC_o), .aeVC_o(aeVC_o),
        .state(state), .cnt_vc0(cnt_vc0), .cnt_vc1(cnt_vc1),
        .error_out(error_out), .idle_out(idle_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state as plain integers 0..4, pipeline as "popped last cycle" flag.
    int            m_state = 0;
    bit            m_pend = 0, m_push0 = 0, m_push1 = 0, m_err = 0, m_pop = 0;
    logic [DW-1:0] m_data = '0;
    int            m_cnt0 = 0, m_cnt1 = 0;
    logic [TW-1:0] m_afmf = '0, m_aemf = '0, m_afvc = '0, m_aevc = '0;

    function automatic bit err_inputs();
        return fifo_error_main | error_vc0 | error_vc1;
    endfunction

    function automatic bit model_pop();
        return (m_state == 2 || m_state == 3) && !init && !fifo_empty_main && !pause_vc0 &&
               !pause_vc1 && !err_inputs();
    endfunction

    task automatic model_update();
        int ns;
        bit enter;
        if (!reset_L) begin
            m_state = 0; m_pend = 0; m_push0 = 0; m_push1 = 0; m_err = 0; m_data = '0;
            m_cnt0 = 0; m_cnt1 = 0; m_afmf = '0; m_aemf = '0; m_afvc = '0; m_aevc = '0;
            return;
        end
        enter  = (m_state != 0) && err_inputs();
        m_cnt0 = (m_cnt0 + int'(m_push0)) % (1 << CW);
        m_cnt1 = (m_cnt1 + int'(m_push1)) % (1 << CW);
        if (m_pend && !enter && m_state != 4) begin
            m_data  = data_demux_vc;
            m_push1 = data_demux_vc[CB];
            m_push0 = !data_demux_vc[CB];
        end else begin
            m_push0 = 0;
            m_push1 = 0;
        end
        if (m_state == 1) begin
            m_afmf = umbral_MF_af; m_aemf = umbral_MF_ae;
            m_afvc = umbral_VC_af; m_aevc = umbral_VC_ae;
        end
        case (m_state)
            0:       ns = 1;
            1:       ns = enter ? 4 : (init ? 1 : 2);
            2:       ns = enter ? 4 : (init ? 1 : (m_pop ? 3 : 2));
            3:       ns = enter ? 4 : (init ? 1 : ((fifo_empty_main && !m_pend) ? 2 : 3));
            default: ns = 4;
        endcase
        m_state = ns;
        if (enter) m_err = 1;
        m_pend = m_pop;
    endtask

    // One clock cycle with the inputs currently applied.
    task automatic step();
        @(negedge clk);
        #1;
        m_pop = model_pop();
        check_val("pop_main", pop_main, m_pop);
        check_val("idle_out", idle_out, (m_state == 2) && fifo_empty_main && empty_vc0 &&
                  empty_vc1 && !m_pend && !m_push0 && !m_push1);
        @(posedge clk);
        model_update();
        #1;
        check_val("state", state, m_state);
        check_val("push_vc0", push_vc0, m_push0);
        check_val("push_vc1", push_vc1, m_push1);
        check_val("data_vc", data_vc, m_data);
        check_val("cnt_vc0", cnt_vc0, m_cnt0);
        check_val("cnt_vc1", cnt_vc1, m_cnt1);
        check_val("error_out", error_out, m_err);
        check_val("thresholds", {afMF_o, aeMF_o, afVC_o, aeVC_o},
                  {m_afmf, m_aemf, m_afvc, m_aevc});
    endtask

    task automatic quiet_inputs();
        init = 0; fifo_empty_main = 1; fifo_error_main = 0; data_demux_vc = '0;
        pause_vc0 = 0; pause_vc1 = 0; error_vc0 = 0; error_vc1 = 0;
        empty_vc0 = 1; empty_vc1 = 1;
    endtask

    // Reset, then load thresholds and return to IDLE.
    task automatic reset_and_init();
        quiet_inputs();
        reset_L = 0;
        step();
        reset_L = 1; init = 1;
        umbral_MF_af = TW'($urandom); umbral_MF_ae = TW'($urandom);
        umbral_VC_af = TW'($urandom); umbral_VC_ae = TW'($urandom);
        step();
        step();
        init = 0;
        step();
    endtask

    task automatic run_random(input int n);
        int err_hold = 0;
        for (int i = 0; i < n; i++) begin
            if (m_state == 4) err_hold++;
            else err_hold = 0;
            reset_L = (err_hold > 3) ? 1'b0 : ($urandom_range(0, 199) != 0);
            init = (m_state == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
            umbral_MF_af = TW'($urandom); umbral_MF_ae = TW'($urandom);
            umbral_VC_af = TW'($urandom); umbral_VC_ae = TW'($urandom);
            fifo_empty_main = ($urandom_range(0, 3) == 0);
            data_demux_vc   = DW'($urandom);
            pause_vc0       = ($urandom_range(0, 4) == 0);
            pause_vc1       = ($urandom_range(0, 4) == 0);
            fifo_error_main = ($urandom_range(0, 399) == 0);
            error_vc0       = ($urandom_range(0, 399) == 0);
            error_vc1       = ($urandom_range(0, 399) == 0);
            empty_vc0       = ($urandom_range(0, 1) == 1);
            empty_vc1       = ($urandom_range(0, 1) == 1);
            step();
        end
    endtask

    initial begin
        quiet_inputs();
        reset_L = 0; init = 1;
        umbral_MF_af = '0; umbral_MF_ae = '0; umbral_VC_af = '0; umbral_VC_ae = '0;
        @(posedge clk);
        #1;

        // Reset held for three cycles.
        repeat (3) step();
        check_val("rst_state", state, 0);
        check_val("rst_outs", {push_vc0, push_vc1, data_vc, cnt_vc0, cnt_vc1, error_out}, 0);

        // Threshold load.
        reset_L = 1;
        umbral_MF_af = 2'd3; umbral_MF_ae = 2'd1; umbral_VC_af = 2'd2; umbral_VC_ae = 2'd1;
        step();
        check_val("init_entry", state, 1);
        step();
        step();
        check_val("thr_loaded", {afMF_o, aeMF_o, afVC_o, aeVC_o}, {2'd3, 2'd1, 2'd2, 2'd1});
        init = 0;
        step();
        check_val("init_exit", state, 2);

        // Two words, one per class.
        fifo_empty_main = 0; data_demux_vc = 6'h25;
        step();
        step();
        check_val("route_vc1", {push_vc1, push_vc0, data_vc}, {2'b10, 6'h25});
        fifo_empty_main = 1; data_demux_vc = 6'h05;
        step();
        check_val("route_vc0", {push_vc1, push_vc0, data_vc}, {2'b01, 6'h05});
        repeat (3) step();
        check_val("cnt_after_two", {cnt_vc1, cnt_vc0}, {8'd1, 8'd1});
        check_val("back_to_idle", state, 2);

        // Backpressure holds pops off.
        fifo_empty_main = 0; pause_vc0 = 1;
        repeat (3) step();
        pause_vc0 = 0;
        step();
        fifo_empty_main = 1;
        repeat (3) step();

        run_random(3000);

        // 256 class-0 words wrap the VC0 counter.
        reset_and_init();
        fifo_empty_main = 0;
        for (int i = 0; i < 256; i++) begin
            data_demux_vc = DW'($urandom_range(0, (1 << CB) - 1));
            step();
        end
        fifo_empty_main = 1;
        repeat (4) step();
        check_val("wrap_cnt0", cnt_vc0, 0);
        check_val("wrap_cnt1", cnt_vc1, 0);

        // Error pulse mid-stream.
        reset_and_init();
        fifo_empty_main = 0; data_demux_vc = 6'h11;
        repeat (3) step();
        error_vc1 = 1;
        step();
        error_vc1 = 0;
        repeat (4) step();
        check_val("err_state", state, 4);
        check_val("err_out", error_out, 1);
        check_val("err_quiet", {pop_main, push_vc0, push_vc1}, 0);
        reset_L = 0;
        step();
        check_val("err_cleared", {state, error_out}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
